system_rx_cmd_decoder: RTL and testbench
========================================

Name: system_rx_cmd_decoder

Overview:
Frame parser between the RX data synchroniser and the system controller, in the reference clock domain. It consumes one-cycle byte strobes, assembles command frames (register write, register read, ALU with operands, ALU without operands) and presents one decoded command to the controller over a valid/ready handshake. Malformed, stalled and overrunning traffic is discarded and flagged.

Parameters:
WIDTH, 8, byte/data width
ADDR_W, 4, register-file address width; taken from the low bits of the address byte
FUNC_W, 4, ALU function width; taken from the low bits of the function byte
TIMEOUT, 1000, maximum i_clk cycles between bytes of one frame
TMO_W, 16, width of the inter-byte timeout counter

Ports:
i_clk  in  1  reference clock
i_rst  in  1  synchronous active-low reset
i_rx_data  in  WIDTH  synchronised received byte
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
i_cmd_ready  in  1  controller accepts the pending command
o_cmd_valid  out  1  decoded command pending
o_cmd_type  out  2  0=RF_WR, 1=RF_RD, 2=ALU_OP, 3=ALU_NOP
o_cmd_addr  out  ADDR_W  register address (RF_WR/RF_RD)
o_cmd_data  out  WIDTH  write data (RF_WR)
o_op_a  out  WIDTH  operand A (ALU_OP)
o_op_b  out  WIDTH  operand B (ALU_OP)
o_alu_func  out  FUNC_W  ALU function (ALU_OP/ALU_NOP)
o_frame_err  out  1  one-cycle pulse: unknown opcode
o_timeout  out  1  one-cycle pulse: partial frame abandoned
o_overrun  out  1  one-cycle pulse: byte dropped while command pending

Behaviour:
- Reset (i_rst=0 at a clock edge): state IDLE, timeout counter 0, all outputs 0. Reset mid-frame or with a command pending discards everything.
- Opcodes in IDLE: 0xAA RF_WR (addr, data); 0xBB RF_RD (addr); 0xCC ALU_OP (opA, opB, func); 0xDD ALU_NOP (func). Any other byte in IDLE: o_frame_err pulses the next cycle, state stays IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, OP_FUNC, NOP_FUNC, ISSUE. Each state advances on exactly one i_rx_valid. Payload bytes are never checked against opcodes (0xAA as data is data).
- Field capture is registered on the accepting strobe: addr = byte[ADDR_W-1:0]; func = byte[FUNC_W-1:0]; upper bits ignored.
- Last byte of a frame: next cycle state=ISSUE, o_cmd_valid=1, type and fields stable. Latency is 1 cycle from the final strobe to o_cmd_valid.
- Fields not used by the current type hold their previous values. Only the fields the type names are valid.
- ISSUE: o_cmd_valid stays high and all fields stay stable until a cycle with i_cmd_ready=1. After that edge, o_cmd_valid=0 and state=IDLE. The decoder accepts a new opcode from the cycle after the handshake.
- Strobe in ISSUE without ready: byte dropped, o_overrun pulses next cycle. Strobe in the same cycle as the handshake is also dropped and flagged, because IDLE is entered only after that edge.
- Timeout: in any state other than IDLE/ISSUE, the counter increments each cycle without a strobe and clears on each strobe. When it reaches TIMEOUT-1 without a strobe: next cycle state=IDLE, counter=0, o_timeout pulses. A strobe in that same cycle wins: the byte is accepted and no timeout occurs. The counter is held at 0 in IDLE/ISSUE.
- Error pulses are exactly one cycle wide. They never coincide with o_cmd_valid rising.

Test Plan:
- Reset then bytes AA,05,3C with i_cmd_ready=1: one cycle after the 3C strobe, o_cmd_valid=1, type=0, addr=5, data=0x3C. Valid drops after one cycle.
- BB,1F with i_cmd_ready=0 for 10 cycles, then 1: type=1, addr=0xF. Valid is held for 11 cycles with fields stable. State returns to IDLE.
- CC,12,34,07 then DD,02: first command type=2, op_a=0x12, op_b=0x34, func=7. After handshake, second command type=3, func=2, op_a/op_b unchanged.
- Byte 0x55 in IDLE: o_frame_err pulses once, no command. A following AA,01,FF decodes normally.
- AA,03 then silence ≥ TIMEOUT cycles: o_timeout pulses once, no command. Separately, a strobe on exactly cycle TIMEOUT-1 is accepted with no timeout.
- Pending command (ready=0) plus strobe 0x77: o_overrun pulse, command fields unchanged. Assert i_rst=0 mid-frame (after CC,12): all outputs 0; a subsequent DD,04 decodes type=3, func=4.

Source files
------------

// File: rtl/system_rx_cmd_decoder.sv
// Byte-stream command frame parser: assembles RF/ALU command frames from RX strobes
// and hands one decoded command at a time to the controller over valid/ready.
module system_rx_cmd_decoder #(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 4,
  parameter int FUNC_W  = 4,
  parameter int TIMEOUT = 1000,
  parameter int TMO_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WIDTH-1:0]  i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_cmd_ready,
  output logic              o_cmd_valid,
  output logic [1:0]        o_cmd_type,
  output logic [ADDR_W-1:0] o_cmd_addr,
  output logic [WIDTH-1:0]  o_cmd_data,
  output logic [WIDTH-1:0]  o_op_a,
  output logic [WIDTH-1:0]  o_op_b,
  output logic [FUNC_W-1:0] o_alu_func,
  output logic              o_frame_err,
  output logic              o_timeout,
  output logic              o_overrun
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, OP_FUNC, NOP_FUNC, ISSUE
  } state_t;

  localparam logic [WIDTH-1:0] OPC_WR  = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] OPC_RD  = WIDTH'(8'hBB);
  localparam logic [WIDTH-1:0] OPC_ALU = WIDTH'(8'hCC);
  localparam logic [WIDTH-1:0] OPC_NOP = WIDTH'(8'hDD);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic [1:0]          type_q, type_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    op_a_q, op_a_d;
  logic [WIDTH-1:0]    op_b_q, op_b_d;
  logic [FUNC_W-1:0]   func_q, func_d;
  logic                ferr_q, ferr_d;
  logic                tmo_q, tmo_d;
  logic                ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    type_d  = type_q;
    addr_d  = addr_q;
    data_d  = data_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    func_d  = func_q;
    ferr_d  = 1'b0;
    tmo_d   = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_rx_valid) begin
          case (i_rx_data)
            OPC_WR:  state_d = WR_ADDR;
            OPC_RD:  state_d = RD_ADDR;
            OPC_ALU: state_d = OP_A;
            OPC_NOP: state_d = NOP_FUNC;
            default: ferr_d  = 1'b1;
          endcase
        end
      end
      ISSUE: begin
        cnt_d = '0;
        // A strobe in the handshake cycle is still dropped: IDLE starts after the edge.
        if (i_rx_valid) ovr_d = 1'b1;
        if (i_cmd_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        if (i_rx_valid) begin
          cnt_d = '0;
          case (state_q)
            WR_ADDR: begin
              addr_d  = i_rx_data[ADDR_W-1:0];
              state_d = WR_DATA;
            end
            WR_DATA: begin
              data_d  = i_rx_data;
              type_d  = 2'd0;
              valid_d = 1'b1;
              state_d = ISSUE;
            end
            RD_ADDR: begin
              addr_d  = i_rx_data[ADDR_W-1:0];
              type_d  = 2'd1;
              valid_d = 1'b1;
              state_d = ISSUE;
            end
            OP_A: begin
              op_a_d  = i_rx_data;
              state_d = OP_B;
            end
            OP_B: begin
              op_b_d  = i_rx_data;
              state_d = OP_FUNC;
            end
            OP_FUNC: begin
              func_d  = i_rx_data[FUNC_W-1:0];
              type_d  = 2'd2;
              valid_d = 1'b1;
              state_d = ISSUE;
            end
            NOP_FUNC: begin
              func_d  = i_rx_data[FUNC_W-1:0];
              type_d  = 2'd3;
              valid_d = 1'b1;
              state_d = ISSUE;
            end
            default: state_d = IDLE;
          endcase
        end else if (cnt_q == TMO_LAST) begin
          cnt_d   = '0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      type_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      func_q  <= '0;
      ferr_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      func_q  <= func_d;
      ferr_q  <= ferr_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_cmd_valid = valid_q;
  assign o_cmd_type  = type_q;
  assign o_cmd_addr  = addr_q;
  assign o_cmd_data  = data_q;
  assign o_op_a      = op_a_q;
  assign o_op_b      = op_b_q;
  assign o_alu_func  = func_q;
  assign o_frame_err = ferr_q;
  assign o_timeout   = tmo_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_system_rx_cmd_decoder.sv
// Directed bench for system_rx_cmd_decoder: frame decode, handshake hold,
// frame error, inter-byte timeout, overrun and mid-frame reset.
module tb_system_rx_cmd_decoder;
  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_type;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data, op_a, op_b;
  logic [3:0] alu_func;
  logic       frame_err, tmo, ovr;

  int n_pass = 0;
  int n_chk  = 0;
  logic seen;

  system_rx_cmd_decoder #(.WIDTH(8), .ADDR_W(4), .FUNC_W(4), .TIMEOUT(TMO), .TMO_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_cmd_ready(cmd_ready), .o_cmd_valid(cmd_valid), .o_cmd_type(cmd_type),
    .o_cmd_addr(cmd_addr), .o_cmd_data(cmd_data), .o_op_a(op_a), .o_op_b(op_b),
    .o_alu_func(alu_func), .o_frame_err(frame_err), .o_timeout(tmo), .o_overrun(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; cmd_ready = 1'b1;
    step(); step();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_fields", {cmd_type, cmd_addr, cmd_data, op_a, op_b, alu_func}, 0);
    chk("rst_pulses", {frame_err, tmo, ovr}, 0);
    rst = 1'b1;
    step();

    // RF_WR with ready already high
    strobe(8'hAA); strobe(8'h05);
    chk("wr_not_yet", cmd_valid, 0);
    strobe(8'h3C);
    chk("wr_valid", cmd_valid, 1);
    chk("wr_type", cmd_type, 0);
    chk("wr_addr", cmd_addr, 5);
    chk("wr_data", cmd_data, 8'h3C);
    step();
    chk("wr_drop", cmd_valid, 0);

    // RF_RD held for 11 cycles while ready is low
    cmd_ready = 1'b0;
    strobe(8'hBB); strobe(8'h1F);
    chk("rd_valid", cmd_valid, 1);
    chk("rd_type", cmd_type, 1);
    chk("rd_addr", cmd_addr, 4'hF);
    seen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(cmd_valid === 1'b1 && cmd_type === 2'd1 && cmd_addr === 4'hF)) seen = 1'b0;
    end
    chk("rd_hold", seen, 1);
    cmd_ready = 1'b1;
    step();
    chk("rd_drop", cmd_valid, 0);

    // ALU_OP then ALU_NOP
    strobe(8'hCC); strobe(8'h12); strobe(8'h34); strobe(8'h07);
    chk("alu_valid", cmd_valid, 1);
    chk("alu_type", cmd_type, 2);
    chk("alu_ops", {op_a, op_b}, 16'h1234);
    chk("alu_func", alu_func, 7);
    chk("alu_addr_held", cmd_addr, 4'hF);
    step();
    chk("alu_drop", cmd_valid, 0);
    strobe(8'hDD); strobe(8'h02);
    chk("nop_valid", cmd_valid, 1);
    chk("nop_type", cmd_type, 3);
    chk("nop_func", alu_func, 2);
    chk("nop_ops_held", {op_a, op_b}, 16'h1234);
    step();

    // Unknown opcode, then a normal frame with an opcode-valued payload byte
    strobe(8'h55);
    chk("ferr_pulse", frame_err, 1);
    chk("ferr_no_cmd", cmd_valid, 0);
    step();
    chk("ferr_clear", frame_err, 0);
    strobe(8'hAA); strobe(8'hAA); strobe(8'hFF);
    chk("after_ferr_valid", cmd_valid, 1);
    chk("after_ferr_fields", {cmd_type, cmd_addr, cmd_data}, {2'd0, 4'hA, 8'hFF});
    step();

    // Silence after a partial frame: timeout after TIMEOUT idle cycles
    strobe(8'hAA); strobe(8'h03);
    seen = 1'b0;
    for (int i = 0; i < TMO - 1; i++) begin
      step();
      seen |= tmo;
    end
    chk("tmo_early", seen, 0);
    step();
    chk("tmo_pulse", tmo, 1);
    chk("tmo_no_cmd", cmd_valid, 0);
    step();
    chk("tmo_clear", tmo, 0);
    strobe(8'hDD); strobe(8'h09);
    chk("after_tmo", {cmd_valid, cmd_type, alu_func}, {1'b1, 2'd3, 4'h9});
    step();

    // Strobe on the last allowed cycle wins over the timeout
    strobe(8'hAA); strobe(8'h03);
    seen = 1'b0;
    for (int i = 0; i < TMO - 1; i++) begin
      step();
      seen |= tmo;
    end
    strobe(8'h44);
    seen |= tmo;
    chk("tmo_edge_no_pulse", seen, 0);
    chk("tmo_edge_cmd", {cmd_valid, cmd_type, cmd_addr, cmd_data}, {1'b1, 2'd0, 4'h3, 8'h44});
    step();
    chk("tmo_edge_after", {tmo, cmd_valid}, 0);

    // Overrun while pending, and in the handshake cycle itself
    cmd_ready = 1'b0;
    strobe(8'hBB); strobe(8'h06);
    chk("ovr_cmd", {cmd_valid, cmd_type, cmd_addr}, {1'b1, 2'd1, 4'h6});
    strobe(8'h77);
    chk("ovr_pulse", ovr, 1);
    chk("ovr_fields", {cmd_valid, cmd_type, cmd_addr, cmd_data}, {1'b1, 2'd1, 4'h6, 8'h44});
    step();
    chk("ovr_clear", ovr, 0);
    cmd_ready = 1'b1;
    strobe(8'hDD);
    chk("ovr_hs_pulse", {ovr, cmd_valid}, {1'b1, 1'b0});
    strobe(8'h0E);
    chk("ovr_hs_dropped", {frame_err, cmd_valid}, {1'b1, 1'b0});

    // Reset mid-frame discards state and clears held fields
    strobe(8'hCC); strobe(8'h12);
    rst = 1'b0;
    step();
    chk("mid_rst_out", {cmd_valid, cmd_type, cmd_addr, cmd_data, op_a, op_b, alu_func, frame_err, tmo, ovr}, 0);
    rst = 1'b1;
    strobe(8'hDD); strobe(8'h04);
    chk("post_rst_cmd", {cmd_valid, cmd_type, alu_func}, {1'b1, 2'd3, 4'h4});
    chk("post_rst_ops", {op_a, op_b}, 0);
    step();
    chk("post_rst_drop", cmd_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
